// File: rtl/calc_result_display.sv
// calc_result_display
//   Output stage of the calculator ALU. On start (in IDLE) it captures the signed
//   W-bit result, converts its magnitude to ND BCD digits with a bit-serial
//   double-dabble engine (one iteration per clock, W iterations), then registers
//   the sign, the BCD digits and the seven-segment patterns in a single cycle.
//
// Ports
//   clk       in   1      rising-edge clock
//   rst       in   1      asynchronous active-high reset
//   start     in   1      request a conversion of result (only honoured in IDLE)
//   result    in   W      signed two's-complement ALU result
//   busy      out  1      conversion in progress
//   done      out  1      one-cycle pulse, display outputs updated this cycle
//   sign      out  1      captured result was negative
//   bcd       out  4*ND   BCD digits, [3:0] = units, never blanked
//   seg_sign  out  7      minus sign pattern (gfedcba, active-high)
//   seg       out  7*ND   digit patterns, [6:0] = units, leading zeros blanked
module calc_result_display #(
  parameter int W  = 9,
  parameter int ND = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [W-1:0]      result,
  output logic              busy,
  output logic              done,
  output logic              sign,
  output logic [4*ND-1:0]   bcd,
  output logic [6:0]        seg_sign,
  output logic [7*ND-1:0]   seg
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t            state_q,    state_d;
  logic [CW-1:0]     cnt_q,      cnt_d;
  logic [W-1:0]      mag_q,      mag_d;
  logic [4*ND-1:0]   scratch_q,  scratch_d;
  logic              sign_int_q, sign_int_d;
  logic              busy_q,     busy_d;
  logic              done_q,     done_d;
  logic              sign_q,     sign_d;
  logic [4*ND-1:0]   bcd_q,      bcd_d;
  logic [6:0]        seg_sign_q, seg_sign_d;
  logic [7*ND-1:0]   seg_q,      seg_d;

  // Single-digit seven-segment decoder, gfedcba active-high.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = 7'h3F;
      4'd1:    p = 7'h06;
      4'd2:    p = 7'h5B;
      4'd3:    p = 7'h4F;
      4'd4:    p = 7'h66;
      4'd5:    p = 7'h6D;
      4'd6:    p = 7'h7D;
      4'd7:    p = 7'h07;
      4'd8:    p = 7'h7F;
      4'd9:    p = 7'h6F;
      default: p = 7'h00;
    endcase
    return p;
  endfunction

  // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
  function automatic logic [4*ND-1:0] dabble_adjust(input logic [4*ND-1:0] s);
    logic [4*ND-1:0] r;
    r = s;
    for (int i = 0; i < ND; i++) begin
      if (s[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = s[4*i +: 4] + 4'd3;
      end else begin
        r[4*i +: 4] = s[4*i +: 4];
      end
    end
    return r;
  endfunction

  // Encodes all digits; a zero digit is blanked only while every digit above it
  // is also zero, and the units digit is always lit.
  function automatic logic [7*ND-1:0] encode_digits(input logic [4*ND-1:0] b);
    logic [7*ND-1:0] s;
    logic            lead;
    s    = '0;
    lead = 1'b1;
    for (int i = ND - 1; i >= 0; i--) begin
      if (lead && (b[4*i +: 4] == 4'd0) && (i != 0)) begin
        s[7*i +: 7] = 7'h00;
      end else begin
        s[7*i +: 7] = seg7(b[4*i +: 4]);
        lead        = 1'b0;
      end
    end
    return s;
  endfunction

  // Next-state and datapath: capture in IDLE, one double-dabble step per SHIFT cycle.
  always_comb begin
    logic [4*ND-1:0] adj;
    logic [4*ND-1:0] scratch_nx;
    logic [W-1:0]    mag_nx;

    state_d    = state_q;
    cnt_d      = cnt_q;
    mag_d      = mag_q;
    scratch_d  = scratch_q;
    sign_int_d = sign_int_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    sign_d     = sign_q;
    bcd_d      = bcd_q;
    seg_sign_d = seg_sign_q;
    seg_d      = seg_q;
    adj        = dabble_adjust(scratch_q);
    {scratch_nx, mag_nx} = {adj, mag_q} << 1;

    case (state_q)
      IDLE: begin
        if (start) begin
          sign_int_d = result[W-1];
          // -(-2^(W-1)) wraps to 2^(W-1), which is the correct unsigned magnitude.
          mag_d      = result[W-1] ? (~result + 1'b1) : result;
          scratch_d  = '0;
          cnt_d      = '0;
          busy_d     = 1'b1;
          state_d    = SHIFT;
        end else begin
          state_d    = IDLE;
        end
      end
      SHIFT: begin
        scratch_d = scratch_nx;
        mag_d     = mag_nx;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == CW'(W - 1)) begin
          // Final iteration: publish straight from the freshly shifted scratch.
          sign_d     = sign_int_q;
          bcd_d      = scratch_nx;
          seg_sign_d = sign_int_q ? 7'h40 : 7'h00;
          seg_d      = encode_digits(scratch_nx);
          busy_d     = 1'b0;
          done_d     = 1'b1;
          state_d    = IDLE;
        end else begin
          state_d    = SHIFT;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      mag_q      <= '0;
      scratch_q  <= '0;
      sign_int_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sign_q     <= 1'b0;
      bcd_q      <= '0;
      seg_sign_q <= 7'h00;
      seg_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mag_q      <= mag_d;
      scratch_q  <= scratch_d;
      sign_int_q <= sign_int_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      sign_q     <= sign_d;
      bcd_q      <= bcd_d;
      seg_sign_q <= seg_sign_d;
      seg_q      <= seg_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign sign     = sign_q;
  assign bcd      = bcd_q;
  assign seg_sign = seg_sign_q;
  assign seg      = seg_q;

endmodule
